image_draw_ctl: RTL

IMAGE_DRAW_CTL -- requirements
Module: image_draw_ctl

---
 rtl/image_draw_ctl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/image_draw_ctl.sv
// Sprite compositor: overlays a ROM image on the VGA background stream.
// Three-stage pipeline aligned with a ROM that has one cycle of read latency.
module image_draw_ctl #(
    parameter int          IMG_W     = 48,
    parameter int          IMG_H     = 64,
    parameter int          KEY_EN    = 0,
    parameter logic [11:0] KEY_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic        r_vblnk_prev;
    logic [11:0] r_xpos_l;
    logic [11:0] r_ypos_l;

    logic [10:0] r1_hcount, r1_vcount;
    logic        r1_hsync, r1_vsync, r1_hblnk, r1_vblnk, r1_inside;
    logic [11:0] r1_rgb;

    logic [10:0] r2_hcount, r2_vcount;
    logic        r2_hsync, r2_vsync, r2_hblnk, r2_vblnk, r2_inside;
    logic [11:0] r2_rgb;

    logic [12:0] w_h13, w_v13;
    logic [12:0] w_x_lo, w_y_lo;
    logic [12:0] w_x_hi, w_y_hi;
    logic        w_inside;
    logic        w_latch;
    logic        w_keyed;
    logic [5:0]  w_x_off, w_y_off;
    logic [11:0] w_addr;
    logic [11:0] w_rgb;

    // 13-bit bounds so an image near the top of the 12-bit range never wraps
    assign w_h13   = {2'b00, hcount_in};
    assign w_v13   = {2'b00, vcount_in};
    assign w_x_lo  = {1'b0, r_xpos_l};
    assign w_y_lo  = {1'b0, r_ypos_l};
    assign w_x_hi  = w_x_lo + 13'(IMG_W);
    assign w_y_hi  = w_y_lo + 13'(IMG_H);

    assign w_inside = (w_h13 >= w_x_lo) && (w_h13 < w_x_hi) &&
                      (w_v13 >= w_y_lo) && (w_v13 < w_y_hi) &&
                      !hblnk_in && !vblnk_in;

    assign w_x_off = hcount_in[5:0] - r_xpos_l[5:0];
    assign w_y_off = vcount_in[5:0] - r_ypos_l[5:0];
    assign w_addr  = w_inside ? {w_y_off, w_x_off} : 12'h000;
    assign w_latch = vblnk_in && !r_vblnk_prev;

    assign w_keyed = (KEY_EN == 1) && (rgb_pixel == KEY_COLOR);

    always_comb begin
        w_rgb = r2_rgb;
        if (r2_hblnk || r2_vblnk)
            w_rgb = 12'h000;
        else if (r2_inside && !w_keyed)
            w_rgb = rgb_pixel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_xpos_l     <= '0;
            r_ypos_l     <= '0;
            pixel_addr   <= '0;
            r1_hcount    <= '0;
            r1_vcount    <= '0;
            r1_hsync     <= 1'b0;
            r1_vsync     <= 1'b0;
            r1_hblnk     <= 1'b0;
            r1_vblnk     <= 1'b0;
            r1_inside    <= 1'b0;
            r1_rgb       <= '0;
            r2_hcount    <= '0;
            r2_vcount    <= '0;
            r2_hsync     <= 1'b0;
            r2_vsync     <= 1'b0;
            r2_hblnk     <= 1'b0;
            r2_vblnk     <= 1'b0;
            r2_inside    <= 1'b0;
            r2_rgb       <= '0;
            hcount_out   <= '0;
            vcount_out   <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_latch) begin
                r_xpos_l <= xpos;
                r_ypos_l <= ypos;
            end
            pixel_addr <= w_addr;
            r1_hcount  <= hcount_in;
            r1_vcount  <= vcount_in;
            r1_hsync   <= hsync_in;
            r1_vsync   <= vsync_in;
            r1_hblnk   <= hblnk_in;
            r1_vblnk   <= vblnk_in;
            r1_inside  <= w_inside;
            r1_rgb     <= rgb_in;
            // stage 2 lines up with the ROM word for stage-1's address
            r2_hcount  <= r1_hcount;
            r2_vcount  <= r1_vcount;
            r2_hsync   <= r1_hsync;
            r2_vsync   <= r1_vsync;
            r2_hblnk   <= r1_hblnk;
            r2_vblnk   <= r1_vblnk;
            r2_inside  <= r1_inside;
            r2_rgb     <= r1_rgb;
            hcount_out <= r2_hcount;
            vcount_out <= r2_vcount;
            hsync_out  <= r2_hsync;
            vsync_out  <= r2_vsync;
            hblnk_out  <= r2_hblnk;
            vblnk_out  <= r2_vblnk;
            rgb_out    <= w_rgb;
        end
    end

endmodule
